// File: rtl/mult_seq_arb_5.sv
// ============================================================================
// Module   : mult_seq_arb_5
// Purpose  : Round-robin arbiter that time-shares one shift-add multiply cell
//            between two requesters, iterating the cell W2 times per product.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_arb_5 #(
    parameter int W1 = 16,
    parameter int W2 = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        in_valid,
    output logic [1:0]        in_ready,
    input  logic [2*W1-1:0]   in_a,
    input  logic [2*W2-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W1-1:0]     out_data,
    output logic              out_id,
    output logic              busy,
    output logic              err,
    output logic              cell_en,
    output logic [W1-1:0]     cell_mult_1,
    output logic [W2-1:0]     cell_mult_2,
    output logic [W1-1:0]     cell_mult_pre,
    input  logic              cell_rdy,
    input  logic [W1-1:0]     cell_mult_1_shift,
    input  logic [W2-1:0]     cell_mult_2_shift,
    input  logic [W1-1:0]     cell_mult_next
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam int             CW     = (W2 > 1) ? $clog2(W2) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(W2 - 1);

    logic [1:0]    r_state;
    logic          r_rr_ptr;
    logic [CW-1:0] r_cnt;
    logic [W1-1:0] r_op_a;
    logic [W2-1:0] r_op_b;
    logic [W1-1:0] r_result;
    logic          r_out_id;
    logic          r_err;

    logic          w_grant_vld;
    logic          w_grant_id;
    logic [W1-1:0] w_sel_a;
    logic [W2-1:0] w_sel_b;

    // Pointer requester wins if valid, otherwise the other one.
    always_comb begin
        w_grant_vld = |in_valid;
        w_grant_id  = in_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
        w_sel_a     = w_grant_id ? in_a[2*W1-1:W1] : in_a[W1-1:0];
        w_sel_b     = w_grant_id ? in_b[2*W2-1:W2] : in_b[W2-1:0];
        in_ready    = 2'b00;
        if (r_state == S_IDLE && w_grant_vld) begin
            in_ready[w_grant_id] = 1'b1;
        end
    end

    // First iteration seeds the cell; later ones close the loop on its outputs.
    always_comb begin
        cell_en       = 1'b0;
        cell_mult_1   = '0;
        cell_mult_2   = '0;
        cell_mult_pre = '0;
        if (r_state == S_RUN) begin
            cell_en = 1'b1;
            if (r_cnt == '0) begin
                cell_mult_1 = r_op_a;
                cell_mult_2 = r_op_b;
            end else begin
                cell_mult_1   = cell_mult_1_shift;
                cell_mult_2   = cell_mult_2_shift;
                cell_mult_pre = cell_mult_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 1'b0;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_out_id <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_out_id <= w_grant_id;
                        r_rr_ptr <= ~w_grant_id;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt != '0 && !cell_rdy) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == C_LAST) begin
                        r_state <= S_CAPT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CAPT: begin
                    r_result <= cell_mult_next;
                    r_state  <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_result;
    assign out_id    = r_out_id;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_arb_5.sv
// ============================================================================
// Module   : tb_mult_seq_arb_5
// Purpose  : Directed self-checking bench for mult_seq_arb_5 with a cell model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_arb_5;

    localparam int W1 = 16;
    localparam int W2 = 8;

    logic              clk;
    logic              rst_n;
    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [2*W1-1:0]   in_a;
    logic [2*W2-1:0]   in_b;
    logic              out_valid;
    logic              out_ready;
    logic [W1-1:0]     out_data;
    logic              out_id;
    logic              busy;
    logic              err;
    logic              cell_en;
    logic [W1-1:0]     cell_mult_1;
    logic [W2-1:0]     cell_mult_2;
    logic [W1-1:0]     cell_mult_pre;
    logic              cell_rdy;
    logic [W1-1:0]     cell_mult_1_shift;
    logic [W2-1:0]     cell_mult_2_shift;
    logic [W1-1:0]     cell_mult_next;

    logic              r_rdy;
    logic              rdy_kill;
    int                n_checks;
    int                n_errors;

    mult_seq_arb_5 #(.W1(W1), .W2(W2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_a              (in_a),
        .in_b              (in_b),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_id            (out_id),
        .busy              (busy),
        .err               (err),
        .cell_en           (cell_en),
        .cell_mult_1       (cell_mult_1),
        .cell_mult_2       (cell_mult_2),
        .cell_mult_pre     (cell_mult_pre),
        .cell_rdy          (cell_rdy),
        .cell_mult_1_shift (cell_mult_1_shift),
        .cell_mult_2_shift (cell_mult_2_shift),
        .cell_mult_next    (cell_mult_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered shift-add cell: one step per enabled clock, cleared when idle.
    always_ff @(posedge clk) begin
        if (!rst_n || !cell_en) begin
            cell_mult_1_shift <= '0;
            cell_mult_2_shift <= '0;
            cell_mult_next    <= '0;
            r_rdy             <= 1'b0;
        end else begin
            cell_mult_1_shift <= cell_mult_1 << 1;
            cell_mult_2_shift <= cell_mult_2 >> 1;
            cell_mult_next    <= cell_mult_pre + (cell_mult_2[0] ? cell_mult_1 : '0);
            r_rdy             <= 1'b1;
        end
    end
    assign cell_rdy = r_rdy & ~rdy_kill;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One request from requester id; hold = cycles of backpressure, fault_cnt = iteration with rdy forced low.
    task automatic do_op(input int id, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int hold, input int fault_cnt);
        int n_en;
        int lat;
        if (id == 0) begin
            in_a[15:0] = a; in_b[7:0] = b; in_valid = 2'b01;
        end else begin
            in_a[31:16] = a; in_b[15:8] = b; in_valid = 2'b10;
        end
        out_ready = 1'b0;
        #1;
        check("in_ready_grant", {30'd0, in_ready}, (id == 0) ? 32'd1 : 32'd2);
        step();
        in_valid = 2'b00;
        n_en = 0;
        lat  = 1;
        while (!out_valid && lat < 30) begin
            if (cell_en) n_en++;
            if (lat - 1 == fault_cnt) begin
                rdy_kill = 1'b1;
                #1;
                check("err_before_fault", {31'd0, err}, 32'd0);
            end
            step();
            rdy_kill = 1'b0;
            if (lat - 1 == fault_cnt) check("err_after_fault", {31'd0, err}, 32'd1);
            lat++;
        end
        check("latency", lat, 10);
        check("cell_en_cycles", n_en, 8);
        check("out_data", {16'd0, out_data}, {16'd0, exp});
        check("out_id", {31'd0, out_id}, id);
        if (hold > 0) begin
            in_valid = 2'b11;
            for (int i = 0; i < hold; i++) begin
                step();
                if (out_valid !== 1'b1 || out_data !== exp || out_id !== id[0] || in_ready !== 2'b00)
                    check("backpressure_hold", {out_valid, in_ready, out_id, 12'd0, out_data},
                          {1'b1, 2'b00, id[0], 12'd0, exp});
            end
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            in_valid = 2'b00;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int exp_id;
        int n_grant;
        int n_res;
        int last_acc;
        n_checks = 0;
        n_errors = 0;
        rdy_kill = 1'b0;
        in_valid = 2'b00;
        in_a     = '0;
        in_b     = '0;
        out_ready = 1'b0;
        do_reset();

        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {16'd0, out_data},  32'd0);
        check("rst_out_id",    {31'd0, out_id},    32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_cell_en",   {31'd0, cell_en},   32'd0);

        do_op(0, 16'h0123, 8'h05, 16'h05AF, 0, -1);
        do_op(1, 16'hFFFF, 8'hFF, 16'hFF01, 0, -1);
        do_op(0, 16'h1234, 8'h00, 16'h0000, 5, -1);

        // Fairness: both valid, 3*4=12 from req0, 5*6=30 from req1.
        do_reset();
        in_a = {16'd5, 16'd3};
        in_b = {8'd6, 8'd4};
        in_valid = 2'b11;
        out_ready = 1'b1;
        n_grant = 0;
        n_res = 0;
        last_acc = -11;
        #1;
        for (int cyc = 0; cyc < 44; cyc++) begin
            if (in_ready != 2'b00) begin
                check("fair_grant", {30'd0, in_ready}, (n_grant % 2 == 0) ? 32'd1 : 32'd2);
                check("fair_spacing", cyc - last_acc, 11);
                last_acc = cyc;
                n_grant++;
            end
            if (out_valid) begin
                exp_id = n_res % 2;
                check("fair_out_id", {31'd0, out_id}, exp_id);
                check("fair_out_data", {16'd0, out_data}, (exp_id == 0) ? 32'd12 : 32'd30);
                n_res++;
            end
            step();
        end
        in_valid = 2'b00;
        out_ready = 1'b0;
        check("fair_grants", n_grant, 4);
        check("fair_results", n_res, 4);

        // Reset while cnt==4.
        in_a[15:0] = 16'h1111;
        in_b[7:0] = 8'hFF;
        in_valid = 2'b01;
        step();
        in_valid = 2'b00;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy",      {31'd0, busy},      32'd0);
        check("midrst_cell_en",   {31'd0, cell_en},   32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        n_res = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) n_res++;
            step();
        end
        check("midrst_no_result", n_res, 0);
        do_op(0, 16'h0123, 8'h05, 16'h05AF, 0, -1);

        // Cell fault at cnt==3; product still correct, err sticky until reset.
        do_op(1, 16'h00FF, 8'h03, 16'h02FD, 0, 3);
        for (int i = 0; i < 3; i++) step();
        check("err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        check("err_cleared", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_seq_arb_5.md
Name: mult_seq_arb_5

Overview:
- Sequences one shift-add multiply cell (16b x 8b, one cell stage per clock) through 8 iterations, feeding each stage's outputs back as the next stage's inputs.
- Shares that cell between two requesters using round-robin arbitration and returns the product with the requester ID.
- Sits in the fft_5 stage between the butterfly/twiddle logic and the shared multiply cell.

Parameters:
- W1, 16, width of multiplicand / product.
- W2, 8, width of multiplier; also the iteration count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  2  per-requester request valid.
- in_ready  out  2  per-requester accept strobe, combinational.
- in_a  in  2*W1  multiplicands; requester i uses [i*W1 +: W1].
- in_b  in  2*W2  multipliers; requester i uses [i*W2 +: W2].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  W1  product mod 2^W1.
- out_id  out  1  requester index of out_data.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky: cell_rdy was low during a feedback iteration.
- cell_en  out  1  cell enable.
- cell_mult_1  out  W1  cell multiplicand input.
- cell_mult_2  out  W2  cell multiplier input.
- cell_mult_pre  out  W1  cell partial-sum input.
- cell_rdy  in  1  cell registered ready.
- cell_mult_1_shift  in  W1  cell output: multiplicand << 1.
- cell_mult_2_shift  in  W2  cell output: multiplier >> 1.
- cell_mult_next  in  W1  cell output: updated partial sum.

Behaviour:
- Cell contract: when en=1, the cell registers one shift-add step next clock and sets rdy=1. When en=0, it clears all its outputs next clock.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; rr_ptr=0; iteration counter cnt=0.
  - result register=0; out_valid=0; out_id=0; out_data=0; err=0.
  - cell_en=0 in the cycle after the reset edge.
  - Reset mid-operation abandons the operation; no result is produced.
- States: IDLE -> RUN -> CAPT -> OUT -> IDLE.
- IDLE:
  - Grant goes to requester rr_ptr if its in_valid=1, else to the other requester if its in_valid=1.
  - in_ready[g]=1 for the granted requester only. in_ready=0 in every other state.
  - On a grant: latch in_a/in_b of g into op_a/op_b, latch out_id=g, set rr_ptr=~g, cnt=0, go to RUN.
  - If both requesters stay valid, grants alternate.
- RUN (exactly W2 cycles, cnt 0..W2-1):
  - cell_en=1.
  - cnt==0: cell_mult_1=op_a, cell_mult_2=op_b, cell_mult_pre=0.
  - cnt>0: cell_mult_1=cell_mult_1_shift, cell_mult_2=cell_mult_2_shift, cell_mult_pre=cell_mult_next (combinational feedback).
  - cnt>0 and cell_rdy=0: set err=1; the operation continues anyway.
  - At cnt==W2-1: go to CAPT.
- CAPT (1 cycle):
  - cell_en=0; result register <= cell_mult_next; go to OUT.
- OUT:
  - out_valid=1; out_data=result register; out_id stays stable.
  - On out_valid&out_ready: go to IDLE and drop out_valid next cycle.
  - No new request is accepted in OUT.
- Cell inputs are 0 whenever cell_en=0.
- Latency, accept at cycle T:
  - cell_en high T+1..T+W2.
  - CAPT at T+W2+1.
  - out_valid first high at T+W2+2 (T+10 for W2=8).
  - Minimum spacing between accepts is W2+3 cycles.
- Arithmetic: unsigned; out_data = (op_a*op_b) mod 2^W1; overflow is silently truncated.
- in_valid dropping after grant has no effect. Requesters must hold operands stable until in_ready.
- Back-to-back: if out_ready=1 on the first OUT cycle, the next accept can occur in IDLE one cycle later.

Test Plan:
- Single request: req0 a=0x0123, b=0x05 at T -> in_ready[0]=1 at T; cell_en high T+1..T+8; out_valid at T+10 with out_data=0x05AF, out_id=0.
- Overflow: a=0xFFFF, b=0xFF -> out_data=0xFF01. Also a=0x1234, b=0x00 -> out_data=0x0000.
- Fairness: both requesters valid continuously, out_ready=1 -> grants 0,1,0,1; out_id alternates; accepts spaced 11 cycles apart.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_data, out_id held; in_ready=0 throughout; exactly one transfer when out_ready rises.
- Reset mid-RUN: rst_n=0 at cnt=4 -> next cycle state IDLE, cell_en=0, busy=0, out_valid=0, no result emitted; a fresh request afterwards yields a correct product.
- Cell fault: force cell_rdy=0 at cnt=3 -> err=1 from the next cycle, stays 1 until reset.
